counter_capture: RTL
====================

# counter_capture

Debug capture stage directly downstream of the 4-bit free-running counter. It samples the counter value every clock into a ring buffer and waits for a masked-compare trigger. It then stores a fixed number of post-trigger samples and freezes, so the window around the trigger can be read back over a simple registered read port. It serves as an on-chip logic-analyser substitute for the hardware-debug exercises.

## Interface
- DATA_W, 4, sample width; matches the counter output.
- DEPTH, 16, buffer entries; power of two, at least 4.
- POST_TRIG, 8, samples stored from the trigger sample onward; range 1..DEPTH.
- AW, $clog2(DEPTH), address width (localparam).
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  DATA_W  sampled value (counter dout).
- arm  in  1  one-cycle pulse; starts a capture from IDLE or DONE.
- trig_value  in  DATA_W  compare value.
- trig_mask  in  DATA_W  1 = bit participates in compare; all-zero mask triggers on first eligible cycle.
- rd_en  in  1  read request; honoured only in DONE.
- rd_addr  in  AW  readout index; 0 = oldest sample.
- rd_data  out  DATA_W  registered read data.
- armed  out  1  high in ARMED or POST.
- triggered  out  1  high in POST or DONE.
- done  out  1  high in DONE.
- trig_pos  out  AW  readout index of the trigger sample; constant DEPTH-POST_TRIG (mod DEPTH).

## Operation
- States: IDLE, ARMED, POST, DONE.
- IDLE: no writes. When arm=1, clear wr_ptr and fill_cnt and go to ARMED.
- ARMED: every cycle write din to mem[wr_ptr], then wr_ptr++ (wraps mod DEPTH), and fill_cnt saturates at DEPTH.
  - Trigger condition: ((din ^ trig_value) & trig_mask) == 0.
  - The trigger is eligible only when fill_cnt >= DEPTH-POST_TRIG, counted before this cycle's write. Earlier matches are ignored.
  - On an eligible trigger, write the trigger sample, set post_cnt = 1, and go to POST. If POST_TRIG = 1, go straight to DONE.
- POST: write every cycle and increment post_cnt. The cycle that writes sample number POST_TRIG goes to DONE.
- DONE: no writes; the buffer is frozen.
  - start_ptr equals wr_ptr (the oldest entry).
  - rd_en=1 gives rd_data = mem[(start_ptr + rd_addr) mod DEPTH] on the next cycle. Otherwise rd_data holds its value.
  - arm=1 restarts the capture in ARMED. If arm and rd_en are asserted together, arm wins and the read is dropped.
- arm in ARMED or POST is ignored. rd_en outside DONE is ignored.
- Reset (asynchronous, including mid-capture): state=IDLE. rd_data, armed, triggered, done, wr_ptr, fill_cnt and post_cnt are all 0. Memory contents are not reset.

## Timing
- arm sampled at edge N gives armed=1 after edge N; the first write is at edge N+1.
- A trigger sampled at edge T gives triggered=1 after edge T.
- done=1 after edge T+POST_TRIG-1.
- Read latency is 1 cycle; back-to-back reads give one result per cycle.
- Status outputs come directly from state registers; there are no combinational paths from inputs to outputs.
- trig_value and trig_mask must be stable while armed=1.

## Configuration
- CAPTURE_FORCE_TRIG_EN defined: adds input force_trig (1 bit). In ARMED, force_trig=1 triggers immediately, bypassing both the compare and the pre-fill requirement. trig_pos is then still reported as DEPTH-POST_TRIG, and entries older than fill_cnt are stale.
- Not defined: the port does not exist, and only the masked compare triggers.

## Structure
- Package counter_capture_pkg: state encoding localparams (ST_IDLE=2'd0, ST_ARMED=2'd1, ST_POST=2'd2, ST_DONE=2'd3) and default DATA_W/DEPTH/POST_TRIG constants.
- One sub-module, capture_ram: simple dual-port, one write port and one registered read port, no reset on the array. It is inferred as distributed or block RAM.
- Control FSM, pointers and counters stay in counter_capture.

## Test plan
- Reset: hold rst_n=0 while clk runs, release mid-cycle → IDLE; done, armed, triggered and rd_data are all 0. Pull rst_n low asynchronously during POST → all outputs 0 immediately; done is never set.
- Basic capture: defaults; din is the counter, arm when din=0, trig_value=5, trig_mask=4'hF.
  - The match at din=5 (fill=5 < 8) is ignored.
  - The next match at din=5 triggers.
  - Readout 0..15 = 13,14,15,0,1,…,12; rd_addr 8 returns 5 = trig_pos.
- Masked trigger: trig_mask=4'b1000, trig_value=4'h8, arm at din=0 → triggers on the first din≥8 after 8 pre-samples (din=8); readout index 8 = 8.
- POST_TRIG=DEPTH (16): trigger on the first match, with no pre-fill required → readout index 0 = trigger value; done 15 cycles after triggered.
- Re-arm and conflicts:
  - arm during ARMED or POST does not restart the capture (same result as the basic capture).
  - arm plus rd_en in DONE → returns to ARMED; rd_data is unchanged.
  - rd_en in IDLE → rd_data stays 0.
- With CAPTURE_FORCE_TRIG_EN: trig_mask=F, trig_value never matching, force_trig pulsed 3 cycles after arm → triggered next cycle; done POST_TRIG-1 cycles later.

Source files
------------

// File: rtl/counter_capture_pkg.sv
// counter_capture_pkg
// Shared constants for the counter_capture debug stage: default sizing,
// the state encoding and the FSM state type.
// No ports (package).
package counter_capture_pkg;

  localparam int DEF_DATA_W    = 4;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_POST_TRIG = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_POST  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ARMED = ST_ARMED,
    S_POST  = ST_POST,
    S_DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/counter_capture_if.sv
// counter_capture_if
// Registered read port of the capture buffer.
//   rd_en    request a read (master -> slave)
//   rd_addr  readout index, 0 = oldest sample (master -> slave)
//   rd_data  registered read data, valid the cycle after rd_en (slave -> master)
interface counter_capture_if #(
  parameter int DATA_W = 4,
  parameter int AW     = 4
) ();

  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);

endinterface

// File: rtl/counter_capture_ram.sv
// capture_ram
// Simple dual-port sample store: one write port, one registered read port.
// The array has no reset so it maps onto distributed or block RAM; only the
// read output register is reset.
//   clk, rst_n      clock, async active-low reset (read register only)
//   we/waddr/wdata  write port
//   re/raddr        read request and address
//   rdata           registered read data, holds when re=0
module capture_ram #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/counter_capture.sv
// counter_capture
// Debug capture stage behind the free-running counter. Samples din into a
// ring buffer while armed, triggers on a masked compare once enough
// pre-trigger history exists, stores POST_TRIG samples from the trigger
// onward, then freezes for readout.
//   clk, rst_n             clock, async active-low reset
//   din                    sampled value
//   arm                    start/restart pulse (honoured in IDLE and DONE)
//   trig_value, trig_mask  masked trigger compare
//   force_trig             immediate trigger in ARMED (only with
//                          CAPTURE_FORCE_TRIG_EN defined)
//   rd                     read port (counter_capture_if.slave)
//   armed, triggered, done status decoded from the state register
//   trig_pos               readout index of the trigger sample
//
// state | meaning
// IDLE  | no capture, waiting for arm
// ARMED | writing pre-trigger history, watching for trigger
// POST  | writing post-trigger samples
// DONE  | buffer frozen, readout allowed
module counter_capture
  import counter_capture_pkg::*;
#(
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int DEPTH     = DEF_DEPTH,
  parameter  int POST_TRIG = DEF_POST_TRIG,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              arm,
  input  logic [DATA_W-1:0] trig_value,
  input  logic [DATA_W-1:0] trig_mask,
`ifdef CAPTURE_FORCE_TRIG_EN
  input  logic              force_trig,
`endif
  counter_capture_if.slave  rd,
  output logic              armed,
  output logic              triggered,
  output logic              done,
  output logic [AW-1:0]     trig_pos
);

  localparam int PRE = DEPTH - POST_TRIG;

  state_t        state, state_nxt;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   fill_cnt;
  logic [AW:0]   post_cnt;
  logic          we, clr, hit, eligible, trig_go, re;

  assign hit      = ((din ^ trig_value) & trig_mask) == '0;
  // fill_cnt is the count before this cycle's write
  assign eligible = fill_cnt >= (AW+1)'(PRE);
`ifdef CAPTURE_FORCE_TRIG_EN
  assign trig_go  = (hit && eligible) || force_trig;
`else
  assign trig_go  = hit && eligible;
`endif

  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    clr       = 1'b0;
    case (state)
      S_IDLE: begin
        if (arm) begin
          state_nxt = S_ARMED;
          clr       = 1'b1;
        end
      end
      S_ARMED: begin
        we = 1'b1;
        if (trig_go) state_nxt = (POST_TRIG == 1) ? S_DONE : S_POST;
      end
      S_POST: begin
        we = 1'b1;
        // this cycle writes sample number post_cnt+1
        if (post_cnt == (AW+1)'(POST_TRIG - 1)) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (arm) begin
          state_nxt = S_ARMED;
          clr       = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      fill_cnt <= '0;
      post_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (clr) begin
        wr_ptr   <= '0;
        fill_cnt <= '0;
        post_cnt <= '0;
      end else if (we) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (fill_cnt != (AW+1)'(DEPTH)) fill_cnt <= fill_cnt + 1'b1;
        if (state == S_ARMED) post_cnt <= trig_go ? (AW+1)'(1) : '0;
        else                  post_cnt <= post_cnt + 1'b1;
      end
    end
  end

  // arm wins over a simultaneous read in DONE
  assign re = (state == S_DONE) && rd.rd_en && !arm;

  capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (re),
    .raddr (wr_ptr + rd.rd_addr),
    .rdata (rd.rd_data)
  );

  assign armed     = (state == S_ARMED) || (state == S_POST);
  assign triggered = (state == S_POST)  || (state == S_DONE);
  assign done      = (state == S_DONE);
  assign trig_pos  = AW'(PRE);

endmodule
